pe_scan_sequencer: RTL

Bit-scan sequencer wrapped around the parameterized priority encoder. It accepts a request word on a valid/ready input and drives the encoder's start/data/done handshake once per set bit. After each result it clears the reported bit, then emits the bit indices highest-first on a valid/ready output stream with a last flag. It is the encoder's direct upstream driver and downstream consumer, turning one-shot MSB detection into a full set-bit enumeration for the arbitration path.

---
 rtl/pe_scan_sequencer.sv | 105 ++++++++++
 1 files changed

// File: rtl/pe_scan_sequencer.sv
// Enumerates the set bits of a request word highest-first by re-launching the MSB encoder once per bit.
// Latency: 3 cycles per bit plus encoder turnaround; input stalls (in_ready=0) until the last beat of a word is taken.
module pe_scan_sequencer #(
    parameter int DATA_LEN   = 8,
    parameter int RESULT_LEN = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_LEN-1:0]   in_data,
    output logic                  enc_start,
    output logic [DATA_LEN-1:0]   enc_data,
    input  logic                  enc_ready,
    input  logic                  enc_done,
    input  logic [RESULT_LEN-1:0] enc_result,
    input  logic                  enc_zero_f,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RESULT_LEN-1:0] out_index,
    output logic                  out_last,
    output logic                  out_empty,
    output logic [RESULT_LEN:0]   out_seq,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, EMIT} state_t;

    state_t                state;
    logic [DATA_LEN-1:0]   work;
    logic [DATA_LEN-1:0]   cleared;
    logic [RESULT_LEN-1:0] idx;
    logic                  last;
    logic                  empty;
    logic [RESULT_LEN:0]   seq;

    // Working word with the bit just reported by the encoder removed.
    always_comb begin
        cleared = work & ~(DATA_LEN'(1) << enc_result);
    end

    // Handshake outputs are gated by rst so nothing is offered during the reset cycle.
    assign in_ready  = rst && (state == IDLE);
    assign enc_start = rst && (state == LAUNCH) && enc_ready;
    assign out_valid = rst && (state == EMIT);
    assign busy      = rst && (state != IDLE);
    assign enc_data  = work;
    assign out_index = idx;
    assign out_last  = last;
    assign out_empty = empty;
    assign out_seq   = seq;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            work  <= '0;
            idx   <= '0;
            seq   <= '0;
            last  <= 1'b0;
            empty <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= in_data;
                        seq   <= '0;
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (enc_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (enc_done) begin
                        if (enc_zero_f) begin
                            empty <= 1'b1;
                            idx   <= '0;
                            last  <= 1'b1;
                        end else begin
                            idx   <= enc_result;
                            empty <= 1'b0;
                            work  <= cleared;
                            last  <= (cleared == '0);
                        end
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (last) begin
                            state <= IDLE;
                        end else begin
                            seq   <= seq + 1'b1;
                            state <= LAUNCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
